// File: rtl/code_engine.sv
`default_nettype none
// ============================================================================
// Module   : code_engine
// Brief    : Keypad code entry buffer with PC/UC/pending-code comparison FSM.
// Revision : 1.0
// ============================================================================
module code_engine #(
    parameter int                  MAX_DIGITS = 6,
    parameter int                  UC_MIN     = 4,
    parameter int                  PC_LEN     = 4,
    parameter logic [4*PC_LEN-1:0] PC_CODE    = 16'h1234,
    parameter logic [15:0]         UC_INIT    = 16'h0000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       read_input,
    input  logic [1:0] compareType,
    input  logic       store,
    output logic       correct_input,
    output logic       data_ready,
    output logic       validLength,
    output logic       validLengthPC
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [CW-1:0] c_MAX      = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] c_UC_MIN   = CW'(UC_MIN);
    localparam logic [CW-1:0] c_PC_LEN   = CW'(PC_LEN);
    localparam logic [CW-1:0] c_UC_ILEN  = CW'(4);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_CMP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_MODE_PC   = 2'b00;
    localparam logic [1:0] c_MODE_UC   = 2'b01;
    localparam logic [1:0] c_MODE_PEND = 2'b10;
    localparam logic [1:0] c_MODE_CAP  = 2'b11;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic          r_bstate;
    logic          r_store_q;
    logic [CW-1:0] r_count;
    logic [3:0]    r_buf  [MAX_DIGITS];
    logic [3:0]    r_ent  [MAX_DIGITS];
    logic [CW-1:0] r_ent_len;
    logic [1:0]    r_ent_mode;
    logic [3:0]    r_pend [MAX_DIGITS];
    logic [CW-1:0] r_pend_len;
    logic [3:0]    r_uc   [MAX_DIGITS];
    logic [CW-1:0] r_uc_len;
    logic [3:0]    r_tgt  [MAX_DIGITS];
    logic [CW-1:0] r_tgt_len;
    logic [CW-1:0] r_idx;
    logic          r_len_ok;
    logic          r_result;

    logic [3:0]    w_pc      [MAX_DIGITS];
    logic [3:0]    w_uc_init [MAX_DIGITS];

    logic          w_press;
    logic          w_key_digit;
    logic          w_key_cancel;
    logic          w_key_term;
    logic          w_term_acc;
    logic          w_cmp_done;
    logic          w_cmp_result;

    // Fixed codes unpacked to one digit per slot, most significant nibble first.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_codes
            if (gi < PC_LEN) begin : g_pc_dig
                assign w_pc[gi] = PC_CODE[4*(PC_LEN-gi)-1 -: 4];
            end else begin : g_pc_pad
                assign w_pc[gi] = 4'h0;
            end
            if (gi < 4) begin : g_uc_dig
                assign w_uc_init[gi] = UC_INIT[4*(4-gi)-1 -: 4];
            end else begin : g_uc_pad
                assign w_uc_init[gi] = 4'h0;
            end
        end
    endgenerate

    // A press event is the release of a held key, seen as a 1->0 on bstate.
    assign w_press      = r_bstate & ~bstate & read_input;
    assign w_key_digit  = w_press & (button <= 4'd6);
    assign w_key_cancel = w_press & (button == 4'd7);
    assign w_key_term   = w_press & ((button == 4'd8) | (button == 4'd9));
    assign w_term_acc   = w_key_term & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));

    assign validLength   = (r_count >= c_UC_MIN) && (r_count <= c_MAX);
    assign validLengthPC = (r_count == c_PC_LEN);

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first CMP cycle checks lengths only; digit comparison follows.
    always_comb begin
        w_state_nxt  = r_state;
        w_cmp_done   = 1'b0;
        w_cmp_result = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_term_acc) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = (r_ent_mode == c_MODE_CAP) ? c_ST_IDLE : c_ST_CMP;
            end
            c_ST_CMP: begin
                if (!r_len_ok) begin
                    if (r_tgt_len != r_ent_len) begin
                        w_cmp_done = 1'b1;
                    end else if (r_ent_len == '0) begin
                        w_cmp_done   = 1'b1;
                        w_cmp_result = 1'b1;
                    end
                end else if (r_tgt[r_idx] != r_ent[r_idx]) begin
                    w_cmp_done = 1'b1;
                end else if (r_idx == (r_ent_len - c_ONE)) begin
                    w_cmp_done   = 1'b1;
                    w_cmp_result = 1'b1;
                end
                if (w_cmp_done) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (w_term_acc) begin
                    w_state_nxt = c_ST_LOAD;
                end else if (w_key_digit | w_key_cancel) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        data_ready    = (r_state == c_ST_DONE);
        correct_input = (r_state == c_ST_DONE) & r_result;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_bstate   <= 1'b0;
            r_store_q  <= 1'b0;
            r_count    <= '0;
            r_ent_len  <= '0;
            r_ent_mode <= c_MODE_PC;
            r_pend_len <= '0;
            r_uc_len   <= c_UC_ILEN;
            r_tgt_len  <= '0;
            r_idx      <= '0;
            r_len_ok   <= 1'b0;
            r_result   <= 1'b0;
            for (int k = 0; k < MAX_DIGITS; k++) begin
                r_buf[k]  <= 4'h0;
                r_ent[k]  <= 4'h0;
                r_pend[k] <= 4'h0;
                r_tgt[k]  <= 4'h0;
                r_uc[k]   <= w_uc_init[k];
            end
        end else begin
            r_bstate  <= bstate;
            r_store_q <= store;

            if (w_term_acc) begin
                r_ent      <= r_buf;
                r_ent_len  <= r_count;
                r_ent_mode <= compareType;
                r_count    <= '0;
            end else if (w_key_cancel) begin
                r_count <= '0;
            end else if (w_key_digit && (r_count < c_MAX)) begin
                r_buf[r_count] <= button;
                r_count        <= r_count + c_ONE;
            end

            if (r_state == c_ST_LOAD) begin
                r_idx    <= '0;
                r_len_ok <= 1'b0;
                case (r_ent_mode)
                    c_MODE_PC: begin
                        r_tgt     <= w_pc;
                        r_tgt_len <= c_PC_LEN;
                    end
                    c_MODE_UC: begin
                        r_tgt     <= r_uc;
                        r_tgt_len <= r_uc_len;
                    end
                    c_MODE_PEND: begin
                        r_tgt     <= r_pend;
                        r_tgt_len <= r_pend_len;
                    end
                    default: begin
                        r_pend     <= r_ent;
                        r_pend_len <= r_ent_len;
                    end
                endcase
            end else if (r_state == c_ST_CMP) begin
                if (w_cmp_done) begin
                    r_result <= w_cmp_result;
                end else if (!r_len_ok) begin
                    r_len_ok <= 1'b1;
                end else begin
                    r_idx <= r_idx + c_ONE;
                end
            end

            // Edge-triggered so a held store does not keep overwriting UC.
            if (store && !r_store_q) begin
                r_uc     <= r_pend;
                r_uc_len <= r_pend_len;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_code_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_engine
// Brief    : Directed self-checking bench for code_engine.
// Revision : 1.0
// ============================================================================
module tb_code_engine;

    logic       hwclk = 1'b0;
    logic       reset;
    logic [3:0] button;
    logic       bstate;
    logic       read_input;
    logic [1:0] compareType;
    logic       store;
    logic       correct_input;
    logic       data_ready;
    logic       validLength;
    logic       validLengthPC;

    int n_checks = 0;
    int n_fail   = 0;

    code_engine dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .button        (button),
        .bstate        (bstate),
        .read_input    (read_input),
        .compareType   (compareType),
        .store         (store),
        .correct_input (correct_input),
        .data_ready    (data_ready),
        .validLength   (validLength),
        .validLengthPC (validLengthPC)
    );

    always #5 hwclk = ~hwclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves time just before the press edge, so combinational flags can be sampled.
    task automatic key_down(input logic [3:0] k);
        @(negedge hwclk);
        button = k;
        bstate = 1'b1;
        @(negedge hwclk);
        bstate = 1'b0;
        #1;
    endtask

    task automatic key_edge();
        @(posedge hwclk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_down(k);
        key_edge();
    endtask

    task automatic press_seq(input logic [3:0] keys [], input int n);
        for (int j = 0; j < n; j++) begin
            press(keys[j]);
        end
    endtask

    // Cycles after the press edge until data_ready, or -1 if the bound expires.
    task automatic wait_ready(input int max_cyc, output int n);
        n = -1;
        for (int j = 1; j <= max_cyc; j++) begin
            @(posedge hwclk);
            #1;
            if (data_ready) begin
                n = j;
                break;
            end
        end
    endtask

    logic [3:0] seq [];
    int         lat;
    logic       seen;

    initial begin
        reset       = 1'b1;
        button      = 4'h0;
        bstate      = 1'b0;
        read_input  = 1'b1;
        compareType = 2'b00;
        store       = 1'b0;
        repeat (3) @(posedge hwclk);
        #1;
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_correct", 32'(correct_input), 32'd0);
        chk("rst_validLength", 32'(validLength), 32'd0);
        chk("rst_validLengthPC", 32'(validLengthPC), 32'd0);
        reset = 1'b0;

        // Keys ignored while read_input is low
        read_input = 1'b0;
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        press_seq(seq, 4);
        key_down(4'd8);
        chk("noread_validLengthPC", 32'(validLengthPC), 32'd0);
        key_edge();
        wait_ready(8, lat);
        chk("noread_no_ready", 32'(lat), 32'hFFFF_FFFF);
        read_input = 1'b1;

        // PC match, 6-cycle latency; compareType change after snapshot is ignored
        press_seq(seq, 4);
        key_down(4'd8);
        chk("pc_validLengthPC", 32'(validLengthPC), 32'd1);
        chk("pc_validLength", 32'(validLength), 32'd1);
        key_edge();
        compareType = 2'b01;
        wait_ready(10, lat);
        chk("pc_match_latency", 32'(lat), 32'd6);
        chk("pc_match_correct", 32'(correct_input), 32'd1);
        repeat (3) @(posedge hwclk);
        #1;
        chk("done_hold", 32'(data_ready), 32'd1);

        // PC mismatch
        compareType = 2'b00;
        seq = '{4'd1, 4'd2, 4'd4, 4'd4};
        press(seq[0]);
        chk("digit_exits_done", 32'(data_ready), 32'd0);
        press(seq[1]);
        press(seq[2]);
        press(seq[3]);
        press(4'd8);
        wait_ready(10, lat);
        chk("pc_mismatch_within6", 32'((lat >= 1) && (lat <= 6)), 32'd1);
        chk("pc_mismatch_correct", 32'(correct_input), 32'd0);
        press(4'd7);
        chk("cancel_clears_ready", 32'(data_ready), 32'd0);

        // Overflow drops digits, cancel clears count
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
        press_seq(seq, 7);
        chk("full_count", 32'(dut.r_count), 32'd6);
        chk("full_validLength", 32'(validLength), 32'd1);
        chk("full_validLengthPC", 32'(validLengthPC), 32'd0);
        press(4'd1);
        press(4'd2);
        chk("full_count_held", 32'(dut.r_count), 32'd6);
        press(4'd7);
        chk("cancel_count", 32'(dut.r_count), 32'd0);
        chk("cancel_ready", 32'(data_ready), 32'd0);

        // UC length mismatch, 2-cycle latency
        compareType = 2'b01;
        seq = '{4'd0, 4'd0, 4'd0};
        press_seq(seq, 3);
        key_down(4'd8);
        chk("short_validLength", 32'(validLength), 32'd0);
        key_edge();
        wait_ready(10, lat);
        chk("len_mismatch_latency", 32'(lat), 32'd2);
        chk("len_mismatch_correct", 32'(correct_input), 32'd0);

        // Capture pending, compare to pending, store, compare to UC
        compareType = 2'b11;
        seq = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd5};
        press_seq(seq, 5);
        press(4'd8);
        wait_ready(4, lat);
        chk("capture_no_ready", 32'(lat), 32'hFFFF_FFFF);
        compareType = 2'b10;
        press_seq(seq, 5);
        press(4'd8);
        wait_ready(10, lat);
        chk("pend_match_latency", 32'(lat), 32'd7);
        chk("pend_match_correct", 32'(correct_input), 32'd1);
        @(negedge hwclk);
        store = 1'b1;
        // store stays high: a new capture must not reach UC
        compareType = 2'b11;
        seq = '{4'd1, 4'd1, 4'd1, 4'd1};
        press_seq(seq, 4);
        press(4'd8);
        repeat (3) @(posedge hwclk);
        compareType = 2'b01;
        seq = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd5};
        press_seq(seq, 5);
        press(4'd9);
        wait_ready(10, lat);
        chk("uc_after_store_ready", 32'(lat), 32'd7);
        chk("uc_after_store_correct", 32'(correct_input), 32'd1);
        @(negedge hwclk);
        store = 1'b0;
        @(negedge hwclk);
        store = 1'b1;
        @(negedge hwclk);
        store = 1'b0;
        seq = '{4'd1, 4'd1, 4'd1, 4'd1};
        press_seq(seq, 4);
        press(4'd8);
        wait_ready(10, lat);
        chk("uc_second_store_correct", 32'(correct_input), 32'd1);

        // Reset on second CMP cycle aborts the compare
        compareType = 2'b00;
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        press_seq(seq, 4);
        press(4'd8);
        repeat (2) @(posedge hwclk);
        #1;
        reset = 1'b1;
        @(posedge hwclk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge hwclk);
            #1;
            seen = seen | data_ready;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_count", 32'(dut.r_count), 32'd0);
        compareType = 2'b01;
        seq = '{4'd0, 4'd0, 4'd0, 4'd0};
        press_seq(seq, 4);
        press(4'd8);
        wait_ready(10, lat);
        chk("uc_reset_latency", 32'(lat), 32'd6);
        chk("uc_reset_correct", 32'(correct_input), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
